// File: rtl/mem_io_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_io_responder_pkg
// Shared types and constants for the byte-serial memory port responder:
//   ADDR_TYPE / MEMPORT_TYPE  - address and data widths of the controller port
//   FLAG_READ / FLAG_WRITE    - encoding of the read/write flag
//   RAM_IO_PORT, IO_CTRL_PORT - I/O window registers (low byte is decoded)
//   IO_SEL_*                  - address bits that select the I/O window
//   decode_access()           - classifies an address into RAM / I/O register
// -----------------------------------------------------------------------------
package mem_io_responder_pkg;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [7:0]  MEMPORT_TYPE;

  localparam logic FLAG_READ  = 1'b0;
  localparam logic FLAG_WRITE = 1'b1;

  localparam ADDR_TYPE RAM_IO_PORT  = 32'h0003_0000;
  localparam ADDR_TYPE IO_CTRL_PORT = 32'h0003_0004;

  // The I/O window is every address whose bits [17:16] are both set.
  localparam int         IO_SEL_HI  = 17;
  localparam int         IO_SEL_LO  = 16;
  localparam logic [1:0] IO_SEL_VAL = 2'b11;

  typedef enum logic [1:0] {
    ACC_RAM      = 2'd0,
    ACC_IO_DATA  = 2'd1,
    ACC_IO_CTRL  = 2'd2,
    ACC_IO_OTHER = 2'd3
  } acc_kind_e;

  // Inside the I/O window only the low address byte picks the register,
  // so aliases of 0x30000 / 0x30004 at other bits [15:8] behave identically.
  function automatic acc_kind_e decode_access(input ADDR_TYPE addr);
    acc_kind_e kind;
    if (addr[IO_SEL_HI:IO_SEL_LO] != IO_SEL_VAL) begin
      kind = ACC_RAM;
    end else if (addr[7:0] == RAM_IO_PORT[7:0]) begin
      kind = ACC_IO_DATA;
    end else if (addr[7:0] == IO_CTRL_PORT[7:0]) begin
      kind = ACC_IO_CTRL;
    end else begin
      kind = ACC_IO_OTHER;
    end
    return kind;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Byte-wide synchronous FIFO, depth 2^FIFO_LOG, used for both UART TX and RX.
//   clk, rst  - clock, asynchronous active-high reset (empties the FIFO)
//   push_i    - write din_i; ignored when full unless a pop happens together
//   din_i     - byte to write
//   pop_i     - remove head; ignored when empty
//   dout_o    - head byte, combinational from storage
//   empty_o   - no bytes stored
//   full_o    - 2^FIFO_LOG bytes stored
//   count_o   - number of bytes stored (FIFO_LOG+1 bits)
// -----------------------------------------------------------------------------
module byte_fifo #(
  parameter int FIFO_LOG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [7:0]        din_i,
  input  logic              pop_i,
  output logic [7:0]        dout_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [FIFO_LOG:0] count_o
);

  localparam int DEPTH = 1 << FIFO_LOG;

  logic [7:0]          mem_q [0:DEPTH-1];
  logic [FIFO_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG:0]   count_q, count_d;
  logic                do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (FIFO_LOG+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle; the freed slot is the one being written.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (FIFO_LOG+1)'(do_push) - (FIFO_LOG+1)'(do_pop);
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
// Responder side of the byte-serial memory port. Every rdy=1 cycle is one
// access: RAM (byte array) or the I/O window (UART TX/RX FIFOs, control).
//   clk, rst             - clock, asynchronous active-high reset
//   rdy                  - global enable for the controller-side access path
//   wr_flag_from_ctrl    - FLAG_READ / FLAG_WRITE
//   addr_from_ctrl       - byte address
//   data_i_from_ctrl     - store byte
//   data_o_to_ctrl       - load byte, valid the cycle after the read address
//   uart_full_to_ctrl    - registered: TX FIFO is at most one slot from full
//   tx_data/tx_valid/tx_ready - TX FIFO head towards the UART transmitter
//   rx_data/rx_valid     - received-byte strobe into the RX FIFO
//   program_done         - sticky, set by a write to IO_CTRL_PORT
//   tx_overflow          - sticky, a TX byte was dropped because FIFO was full
// -----------------------------------------------------------------------------
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int FIFO_LOG = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        wr_flag_from_ctrl,
  input  logic [31:0] addr_from_ctrl,
  input  logic [7:0]  data_i_from_ctrl,
  output logic [7:0]  data_o_to_ctrl,
  output logic        uart_full_to_ctrl,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int DEPTH = 1 << FIFO_LOG;
  localparam int CW    = FIFO_LOG + 1;

  // ---------------------------------------------------------------- decode
  acc_kind_e acc_kind;
  logic      acc_rd, acc_wr;

  assign acc_kind = decode_access(addr_from_ctrl);
  assign acc_wr   = rdy && (wr_flag_from_ctrl == FLAG_WRITE);
  assign acc_rd   = rdy && (wr_flag_from_ctrl == FLAG_READ);

  // ------------------------------------------------------------------- RAM
  logic [7:0]        ram_mem [0:(1 << RAM_AW)-1];
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        ram_rdata_q;
  logic              ram_we, ram_re;

  assign ram_idx = addr_from_ctrl[RAM_AW-1:0];
  assign ram_we  = acc_wr && (acc_kind == ACC_RAM);
  assign ram_re  = acc_rd && (acc_kind == ACC_RAM);

  // Single-port array with registered read. Reads and writes never share a
  // cycle, so a read right after a write to the same byte sees the new value.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= data_i_from_ctrl;
    end
    if (ram_re) begin
      ram_rdata_q <= ram_mem[ram_idx];
    end
  end

  // ----------------------------------------------------------------- FIFOs
  logic          tx_push, tx_pop, tx_empty, tx_full;
  logic [CW-1:0] tx_count;
  logic          rx_pop, rx_empty, rx_full;
  logic [7:0]    rx_dout;
  logic [CW-1:0] rx_count;

  assign tx_valid = !tx_empty;
  assign tx_push  = acc_wr && (acc_kind == ACC_IO_DATA);
  assign tx_pop   = tx_valid && tx_ready;
  // Only a real IO_DATA read pops RX; the idle address-0 read is a RAM read.
  assign rx_pop   = acc_rd && (acc_kind == ACC_IO_DATA) && !rx_empty;

  byte_fifo #(.FIFO_LOG(FIFO_LOG)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .din_i   (data_i_from_ctrl),
    .pop_i   (tx_pop),
    .dout_o  (tx_data),
    .empty_o (tx_empty),
    .full_o  (tx_full),
    .count_o (tx_count)
  );

  byte_fifo #(.FIFO_LOG(FIFO_LOG)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_valid),
    .din_i   (rx_data),
    .pop_i   (rx_pop),
    .dout_o  (rx_dout),
    .empty_o (rx_empty),
    .full_o  (rx_full),
    .count_o (rx_count)
  );

  // ----------------------------------------------------- control registers
  logic [7:0]    io_rdata_q, io_rdata_d;
  logic          rd_sel_ram_q, rd_sel_ram_d;
  logic          uart_full_q, uart_full_d;
  logic          program_done_q, program_done_d;
  logic          tx_overflow_q, tx_overflow_d;
  logic          tx_push_ok;
  logic [CW-1:0] tx_count_d;

  // Mirrors the TX FIFO acceptance rule to predict next cycle's occupancy.
  assign tx_push_ok = tx_push && (!tx_full || tx_pop);
  assign tx_count_d = tx_count + CW'(tx_push_ok) - CW'(tx_pop);

  always_comb begin
    io_rdata_d     = io_rdata_q;
    rd_sel_ram_d   = rd_sel_ram_q;
    program_done_d = program_done_q;
    tx_overflow_d  = tx_overflow_q;
    // One byte of headroom covers a store already in flight when sampled.
    uart_full_d    = (tx_count_d >= CW'(DEPTH - 1));

    if (acc_rd) begin
      rd_sel_ram_d = (acc_kind == ACC_RAM);
      case (acc_kind)
        ACC_IO_DATA: io_rdata_d = rx_empty ? 8'h00 : rx_dout;
        ACC_IO_CTRL: io_rdata_d = {6'b0, !rx_empty, tx_full};
        default:     io_rdata_d = 8'h00;
      endcase
    end

    if (acc_wr && (acc_kind == ACC_IO_CTRL)) begin
      program_done_d = 1'b1;
    end
    if (tx_push && !tx_push_ok) begin
      tx_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_rdata_q     <= 8'h00;
      rd_sel_ram_q   <= 1'b0;
      uart_full_q    <= 1'b0;
      program_done_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
    end else begin
      io_rdata_q     <= io_rdata_d;
      rd_sel_ram_q   <= rd_sel_ram_d;
      uart_full_q    <= uart_full_d;
      program_done_q <= program_done_d;
      tx_overflow_q  <= tx_overflow_d;
    end
  end

  // The load byte comes from whichever registered source the last read used;
  // after reset the I/O register (cleared to 0) is selected.
  assign data_o_to_ctrl    = rd_sel_ram_q ? ram_rdata_q : io_rdata_q;
  assign uart_full_to_ctrl = uart_full_q;
  assign program_done      = program_done_q;
  assign tx_overflow       = tx_overflow_q;

  logic unused_sig;
  assign unused_sig = ^{addr_from_ctrl, rx_count, rx_full};

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

  localparam int RAM_AW = 17;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        wr_flag = 1'b0;
  logic [31:0] addr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        uart_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        program_done;
  logic        tx_overflow;

  always #5 clk = ~clk;

  mem_io_responder #(.RAM_AW(RAM_AW), .FIFO_LOG(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .wr_flag_from_ctrl (wr_flag),
    .addr_from_ctrl    (addr),
    .data_i_from_ctrl  (din),
    .data_o_to_ctrl    (dout),
    .uart_full_to_ctrl (uart_full),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .program_done      (program_done),
    .tx_overflow       (tx_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ------------------------------------------------------ behavioural model
  logic [7:0] ram_m [int];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] exp_dout;
  bit         exp_dout_known;
  bit         exp_full, exp_done, exp_ovf;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    exp_dout       = 8'h00;
    exp_dout_known = 1'b1;
    exp_full       = 1'b0;
    exp_done       = 1'b0;
    exp_ovf        = 1'b0;
  endtask

  // One access per rdy=1 cycle, evaluated on the values present at the edge.
  task automatic model_edge();
    int         kind;
    int         idx;
    bit         txpop, txpush, rxpop;
    logic [7:0] status;
    if (rst) begin
      model_reset();
      return;
    end
    if (addr[17:16] != 2'b11) kind = 0;
    else if (addr[7:0] == 8'h00) kind = 1;
    else if (addr[7:0] == 8'h04) kind = 2;
    else kind = 3;
    idx    = int'(addr & ((32'd1 << RAM_AW) - 1));
    txpop  = (txq.size() > 0) && tx_ready;
    txpush = 1'b0;
    rxpop  = 1'b0;
    status = {6'b0, rxq.size() > 0, txq.size() == DEPTH};
    if (rdy && !wr_flag) begin
      exp_dout_known = 1'b1;
      case (kind)
        0: if (ram_m.exists(idx)) exp_dout = ram_m[idx];
           else exp_dout_known = 1'b0;
        1: if (rxq.size() > 0) begin exp_dout = rxq[0]; rxpop = 1'b1; end
           else exp_dout = 8'h00;
        2: exp_dout = status;
        default: exp_dout = 8'h00;
      endcase
    end
    if (rdy && wr_flag) begin
      case (kind)
        0: ram_m[idx] = din;
        1: txpush = 1'b1;
        2: exp_done = 1'b1;
        default: ;
      endcase
    end
    if (txpop) void'(txq.pop_front());
    if (txpush) begin
      if (txq.size() < DEPTH) txq.push_back(din);
      else exp_ovf = 1'b1;
    end
    exp_full = (txq.size() >= DEPTH - 1);
    if (rxpop) void'(rxq.pop_front());
    if (rx_valid && rxq.size() < DEPTH) rxq.push_back(rx_data);
  endtask

  task automatic compare_all();
    if (exp_dout_known) chk("data_o", dout, exp_dout);
    chk("uart_full", 8'(uart_full), 8'(exp_full));
    chk("tx_valid", 8'(tx_valid), 8'(txq.size() > 0));
    if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
    chk("program_done", 8'(program_done), 8'(exp_done));
    chk("tx_overflow", 8'(tx_overflow), 8'(exp_ovf));
  endtask

  // Inputs are set at the falling edge; the model steps at the rising edge
  // and the outputs are compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic acc(input logic wr, input logic [31:0] a, input logic [7:0] d);
    rdy = 1'b1; wr_flag = wr; addr = a; din = d;
    cycle();
  endtask

  task automatic idle();
    acc(1'b0, 32'h0, 8'h00);
  endtask

  initial begin
    model_reset();
    // Reset state
    rst = 1'b1;
    #3;
    chk("rst_data_o", dout, 8'h00);
    chk("rst_uart_full", 8'(uart_full), 8'h00);
    chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_program_done", 8'(program_done), 8'h00);
    chk("rst_tx_overflow", 8'(tx_overflow), 8'h00);
    cycle();
    rst = 1'b0;
    cycle();

    // RAM write then read back next cycle
    acc(1'b1, 32'h0001_0010, 8'hA5);
    acc(1'b0, 32'h0001_0010, 8'h00);
    chk("ram_rd_A5", dout, 8'hA5);
    acc(1'b1, 32'h0000_0010, 8'hA5);
    acc(1'b0, 32'h0000_0010, 8'h00);
    chk("ram_rd_A5_low", dout, 8'hA5);

    // Fill TX with tx_ready low
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      acc(1'b1, 32'h0003_0000, 8'(8'h11 + i));
      if (i == 5) chk("uart_full_after6", 8'(uart_full), 8'h00);
    end
    chk("uart_full_after7", 8'(uart_full), 8'h01);
    acc(1'b1, 32'h0003_0000, 8'h18);
    chk("ovf_after8", 8'(tx_overflow), 8'h00);
    acc(1'b1, 32'h0003_0000, 8'h19);
    chk("ovf_after9", 8'(tx_overflow), 8'h01);
    acc(1'b0, 32'h0003_0004, 8'h00);
    chk("status_tx_full", dout, 8'h01);

    // Drain TX
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_seq", tx_data, 8'(8'h11 + i));
      idle();
    end
    chk("tx_drained_valid", 8'(tx_valid), 8'h00);
    chk("tx_drained_full", 8'(uart_full), 8'h00);
    tx_ready = 1'b0;

    // RX pulse and pops
    rx_data = 8'h42; rx_valid = 1'b1;
    idle();
    rx_valid = 1'b0;
    acc(1'b0, 32'h0003_0004, 8'h00);
    chk("status_rx", dout, 8'h02);
    acc(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_pop_42", dout, 8'h42);
    acc(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_pop_empty", dout, 8'h00);

    // Idle reads must not pop RX; program_done is sticky
    rx_valid = 1'b1;
    idle();
    rx_valid = 1'b0;
    repeat (20) idle();
    acc(1'b0, 32'h0003_0004, 8'h00);
    chk("idle_status", dout, 8'h02);
    acc(1'b0, 32'h0003_0000, 8'h00);
    chk("idle_rx_kept", dout, 8'h42);
    acc(1'b1, 32'h0003_0004, 8'h00);
    chk("program_done_set", 8'(program_done), 8'h01);
    repeat (3) idle();
    chk("program_done_sticky", 8'(program_done), 8'h01);

    // Async reset mid-stream with a rdy=0 write presented
    for (int i = 0; i < 3; i++) acc(1'b1, 32'h0003_0000, 8'(8'h21 + i));
    chk("tx_3_valid", 8'(tx_valid), 8'h01);
    rdy = 1'b0; wr_flag = 1'b1; addr = 32'h0000_0010; din = 8'h5A;
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_data_o", dout, 8'h00);
    chk("arst_uart_full", 8'(uart_full), 8'h00);
    chk("arst_tx_valid", 8'(tx_valid), 8'h00);
    chk("arst_program_done", 8'(program_done), 8'h00);
    chk("arst_tx_overflow", 8'(tx_overflow), 8'h00);
    model_reset();
    cycle();
    rst = 1'b0;
    acc(1'b0, 32'h0000_0010, 8'h00);
    chk("rdy0_write_blocked", dout, 8'hA5);
    acc(1'b0, 32'h0003_0004, 8'h00);
    chk("post_rst_status", dout, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int sel;
      sel      = int'($urandom_range(0, 9));
      rdy      = ($urandom_range(0, 9) != 0);
      wr_flag  = 1'($urandom_range(0, 1));
      din      = 8'($urandom);
      case (sel)
        0, 1, 2: addr = {14'($urandom), 2'b00, 8'h01, 4'h0, 4'($urandom)};
        3, 4:    addr = {14'($urandom), 2'b01, 8'hFF, 4'h0, 4'($urandom)};
        5:       addr = 32'h0;
        6, 7:    addr = {14'($urandom), 2'b11, 8'($urandom), 8'h00};
        8:       addr = {14'($urandom), 2'b11, 8'($urandom), 8'h04};
        default: addr = {14'($urandom), 2'b11, 8'($urandom), 8'($urandom)};
      endcase
      if (n < 2000) tx_ready = ($urandom_range(0, 9) == 0);
      else          tx_ready = ($urandom_range(0, 1) == 0);
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
